id_ex_pipe_reg: RTL and testbench
=================================

// Module: id_ex_pipe_reg
// PURPOSE
//   ID/EX pipeline register of the 5-stage MIPS core, directly downstream of the ID control unit.
//   Captures control signals, operands, immediate and register numbers from ID for use by EX.
//   Contains the load-use hazard detector that drives the stall/bubble line back to PC, IF/ID and
//   the control unit (hazardMux), plus bubble insertion, flush and downstream-hold handling.
// PARAMETERS
//   DATA_W   32  operand / immediate / PC width
//   REG_AW   5   register-number width
//   ALUOP_W  6   aluop width (matches control unit)
// PORTS
//   clk            in   1        rising-edge clock
//   rst            in   1        reset, asynchronous, active-low (0 = reset)
//   id_valid       in   1        ID holds a real instruction
//   id_branch_eq   in   1        control: beq
//   id_branch_ne   in   1        control: bne
//   id_aluop       in   ALUOP_W  control: ALU operation
//   id_memread     in   1        control: load
//   id_memwrite    in   1        control: store
//   id_memtoreg    in   1        control: writeback from memory
//   id_regdst      in   1        control: 1 = dest rd, 0 = dest rt
//   id_regwrite    in   1        control: register write
//   id_alusrc      in   1        control: 1 = immediate operand
//   id_jump        in   1        control: j
//   id_pc4         in   DATA_W   PC+4 of ID instruction
//   id_rs_data     in   DATA_W   register-file read port A
//   id_rt_data     in   DATA_W   register-file read port B
//   id_imm         in   DATA_W   sign-extended immediate
//   id_rs, id_rt, id_rd in REG_AW  register numbers
//   flush          in   1        branch/jump taken in EX: kill ID instruction
//   ex_hold        in   1        downstream (MEM) busy: freeze this stage
//   ex_*           out  (as in)  registered copies of every id_* above (ex_valid, ex_aluop, ...)
//   ex_wreg        out  REG_AW   destination reg = regdst ? rd : rt, resolved at capture
//   id_stall       out  1        comb.: hold PC and IF/ID, drive control unit hazardMux
// BEHAVIOUR
//   - Reset (rst=0, async): all ex_* outputs and ex_wreg = 0; id_stall follows comb. rule (=0).
//   - Bubble = ex_valid 0, all ex_ control bits 0 (incl. ex_regwrite=0), ex_aluop 0, data 0.
//   - id_uses_rt = ~id_alusrc | id_memwrite | id_branch_eq | id_branch_ne.
//   - load_use = ex_valid & ex_memread & id_valid & (ex_rt != 0) &
//       ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
//   - id_stall = (load_use & ~flush) | ex_hold. Purely combinational, same cycle.
//   - Per rising edge, priority: flush > ex_hold > load_use > capture.
//     flush: load bubble (even if ex_hold=1). ex_hold: all ex_* keep value.
//     load_use: load bubble; ID holds, instruction re-presented next cycle.
//     capture: ex_* <= id_*; ex_valid <= id_valid; ex_wreg computed.
//   - Latency: 1 cycle ID -> EX. Load-use costs exactly one bubble (forwarding covers MEM->EX).
//   - id_valid=0 captured as ex_valid=0 with control bits forced 0 (no stray regwrite).
//   - rst asserted mid-stall clears stage immediately; no pending bubble survives reset.
// CONFIGURATION
//   ID_EX_STATS_EN defined: adds output bubble_cnt [15:0]; +1 on every edge loading a bubble
//     due to load_use or flush (not ex_hold, not id_valid=0); saturates at 16'hFFFF; reset 0.
//   Undefined: no bubble_cnt port, no counter logic; all other behaviour identical.
// TESTING
//   1 Reset: rst=0 mid-run with ex_regwrite=1 -> all ex_* 0 asynchronously, id_stall=0.
//   2 Pass-through: addi id_rt=8, id_imm=5, id_regdst=0 -> next edge ex_wreg=8, ex_alusrc=1, ex_valid=1.
//   3 Load-use: ex lw ex_rt=9; ID add id_rs=9 -> id_stall=1; next edge ex_valid=0, ex_regwrite=0;
//     then id_stall=0 and add captured.
//   4 No false hazard: ex lw ex_rt=0, ID id_rs=0 -> id_stall=0; ex lw rt=9, ID addi id_rt=9 -> 0.
//   5 Flush vs hold: flush=1 & ex_hold=1 -> bubble loaded; ex_hold=1 alone -> ex_* unchanged 3 cycles.
//   6 ID_EX_STATS_EN: 3 load-use + 2 flush events -> bubble_cnt=5; preload 16'hFFFF + event -> FFFF.

Source files
------------

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX stage bundle: instruction fields from ID, redirect/hold controls,
// the registered EX copies and the stall line back to the front end.
//
// Handshake: id_valid marks a real instruction presented by ID. id_stall is
// the back-pressure line: while id_stall=1 the producer must keep presenting
// the same instruction, and it is taken on the first rising edge where
// id_stall=0. flush overrides everything and discards the ID instruction.
interface id_ex_pipe_reg_if #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 6
);
  logic               id_valid;
  logic               id_branch_eq;
  logic               id_branch_ne;
  logic [ALUOP_W-1:0] id_aluop;
  logic               id_memread;
  logic               id_memwrite;
  logic               id_memtoreg;
  logic               id_regdst;
  logic               id_regwrite;
  logic               id_alusrc;
  logic               id_jump;
  logic [DATA_W-1:0]  id_pc4;
  logic [DATA_W-1:0]  id_rs_data;
  logic [DATA_W-1:0]  id_rt_data;
  logic [DATA_W-1:0]  id_imm;
  logic [REG_AW-1:0]  id_rs;
  logic [REG_AW-1:0]  id_rt;
  logic [REG_AW-1:0]  id_rd;
  logic               flush;
  logic               ex_hold;

  logic               ex_valid;
  logic               ex_branch_eq;
  logic               ex_branch_ne;
  logic [ALUOP_W-1:0] ex_aluop;
  logic               ex_memread;
  logic               ex_memwrite;
  logic               ex_memtoreg;
  logic               ex_regdst;
  logic               ex_regwrite;
  logic               ex_alusrc;
  logic               ex_jump;
  logic [DATA_W-1:0]  ex_pc4;
  logic [DATA_W-1:0]  ex_rs_data;
  logic [DATA_W-1:0]  ex_rt_data;
  logic [DATA_W-1:0]  ex_imm;
  logic [REG_AW-1:0]  ex_rs;
  logic [REG_AW-1:0]  ex_rt;
  logic [REG_AW-1:0]  ex_rd;
  logic [REG_AW-1:0]  ex_wreg;
  logic               id_stall;

  modport master (
    output id_valid, id_branch_eq, id_branch_ne, id_aluop, id_memread, id_memwrite,
           id_memtoreg, id_regdst, id_regwrite, id_alusrc, id_jump, id_pc4,
           id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, flush, ex_hold,
    input  ex_valid, ex_branch_eq, ex_branch_ne, ex_aluop, ex_memread, ex_memwrite,
           ex_memtoreg, ex_regdst, ex_regwrite, ex_alusrc, ex_jump, ex_pc4,
           ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_wreg, id_stall
  );

  modport slave (
    input  id_valid, id_branch_eq, id_branch_ne, id_aluop, id_memread, id_memwrite,
           id_memtoreg, id_regdst, id_regwrite, id_alusrc, id_jump, id_pc4,
           id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, flush, ex_hold,
    output ex_valid, ex_branch_eq, ex_branch_ne, ex_aluop, ex_memread, ex_memwrite,
           ex_memtoreg, ex_regdst, ex_regwrite, ex_alusrc, ex_jump, ex_pc4,
           ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_wreg, id_stall
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// flush and downstream hold. Edge priority: flush > ex_hold > load_use > capture.
// Optional feature macro ID_EX_STATS_EN adds a saturating bubble_cnt output
// counting bubbles caused by load-use or flush.
module id_ex_pipe_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 6
) (
  input logic clk,
  input logic rst,
  id_ex_pipe_reg_if.slave bus
`ifdef ID_EX_STATS_EN
  ,
  output logic [15:0] bubble_cnt
`endif
);

  typedef struct packed {
    logic               valid;
    logic               branch_eq;
    logic               branch_ne;
    logic [ALUOP_W-1:0] aluop;
    logic               memread;
    logic               memwrite;
    logic               memtoreg;
    logic               regdst;
    logic               regwrite;
    logic               alusrc;
    logic               jump;
    logic [DATA_W-1:0]  pc4;
    logic [DATA_W-1:0]  rs_data;
    logic [DATA_W-1:0]  rt_data;
    logic [DATA_W-1:0]  imm;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic [REG_AW-1:0]  rd;
    logic [REG_AW-1:0]  wreg;
  } stage_t;

  stage_t id_s;
  stage_t ex_q;
  logic   uses_rt;
  logic   load_use;

  // Gather the ID instruction and resolve its destination register up front.
  always_comb begin
    id_s           = '0;
    id_s.valid     = bus.id_valid;
    id_s.branch_eq = bus.id_branch_eq;
    id_s.branch_ne = bus.id_branch_ne;
    id_s.aluop     = bus.id_aluop;
    id_s.memread   = bus.id_memread;
    id_s.memwrite  = bus.id_memwrite;
    id_s.memtoreg  = bus.id_memtoreg;
    id_s.regdst    = bus.id_regdst;
    id_s.regwrite  = bus.id_regwrite;
    id_s.alusrc    = bus.id_alusrc;
    id_s.jump      = bus.id_jump;
    id_s.pc4       = bus.id_pc4;
    id_s.rs_data   = bus.id_rs_data;
    id_s.rt_data   = bus.id_rt_data;
    id_s.imm       = bus.id_imm;
    id_s.rs        = bus.id_rs;
    id_s.rt        = bus.id_rt;
    id_s.rd        = bus.id_rd;
    id_s.wreg      = bus.id_regdst ? bus.id_rd : bus.id_rt;
  end

  // A load in EX whose target (never $0) is read by the ID instruction.
  always_comb begin
    uses_rt  = ~bus.id_alusrc | bus.id_memwrite | bus.id_branch_eq | bus.id_branch_ne;
    load_use = ex_q.valid & ex_q.memread & bus.id_valid & (ex_q.rt != '0) &
               ((ex_q.rt == bus.id_rs) | (uses_rt & (ex_q.rt == bus.id_rt)));
  end

  assign bus.id_stall = (load_use & ~bus.flush) | bus.ex_hold;

  // Stage register: flush and load-use load a bubble, hold freezes, else capture.
  // An invalid ID slot is captured as a full bubble so no control bit leaks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q <= '0;
    end else if (bus.flush) begin
      ex_q <= '0;
    end else if (bus.ex_hold) begin
      ex_q <= ex_q;
    end else if (load_use || !bus.id_valid) begin
      ex_q <= '0;
    end else begin
      ex_q <= id_s;
    end
  end

`ifdef ID_EX_STATS_EN
  // Count bubbles from load-use or flush; sticks at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= '0;
    end else if ((bus.flush || (!bus.ex_hold && load_use)) && (bubble_cnt != 16'hFFFF)) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_branch_eq = ex_q.branch_eq;
  assign bus.ex_branch_ne = ex_q.branch_ne;
  assign bus.ex_aluop     = ex_q.aluop;
  assign bus.ex_memread   = ex_q.memread;
  assign bus.ex_memwrite  = ex_q.memwrite;
  assign bus.ex_memtoreg  = ex_q.memtoreg;
  assign bus.ex_regdst    = ex_q.regdst;
  assign bus.ex_regwrite  = ex_q.regwrite;
  assign bus.ex_alusrc    = ex_q.alusrc;
  assign bus.ex_jump      = ex_q.jump;
  assign bus.ex_pc4       = ex_q.pc4;
  assign bus.ex_rs_data   = ex_q.rs_data;
  assign bus.ex_rt_data   = ex_q.rt_data;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_rs        = ex_q.rs;
  assign bus.ex_rt        = ex_q.rt;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_wreg      = ex_q.wreg;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed scenarios plus randomized pipeline
// traffic against an instruction-level model of the EX slot.
module tb_id_ex_pipe_reg;
  localparam int DATA_W = 32, REG_AW = 5, ALUOP_W = 6;

  typedef struct packed {
    logic        valid, beq, bne;
    logic [5:0]  aluop;
    logic        memread, memwrite, memtoreg, regdst, regwrite, alusrc, jump;
    logic [31:0] pc4, rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
  } instr_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ALUOP_W(ALUOP_W)) bus ();
`ifdef ID_EX_STATS_EN
  logic [15:0] bubble_cnt;
`endif

  id_ex_pipe_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ALUOP_W(ALUOP_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ID_EX_STATS_EN
    ,
    .bubble_cnt(bubble_cnt)
`endif
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_id(input instr_t i);
    bus.id_valid = i.valid;  bus.id_branch_eq = i.beq;  bus.id_branch_ne = i.bne;
    bus.id_aluop = i.aluop;  bus.id_memread = i.memread; bus.id_memwrite = i.memwrite;
    bus.id_memtoreg = i.memtoreg; bus.id_regdst = i.regdst; bus.id_regwrite = i.regwrite;
    bus.id_alusrc = i.alusrc; bus.id_jump = i.jump; bus.id_pc4 = i.pc4;
    bus.id_rs_data = i.rs_data; bus.id_rt_data = i.rt_data; bus.id_imm = i.imm;
    bus.id_rs = i.rs; bus.id_rt = i.rt; bus.id_rd = i.rd;
  endtask

  task automatic cyc(input instr_t i, input bit fl, input bit hd);
    @(negedge clk);
    set_id(i);
    bus.flush = fl;
    bus.ex_hold = hd;
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  function automatic instr_t cur_id();
    instr_t i;
    i.valid = bus.id_valid; i.beq = bus.id_branch_eq; i.bne = bus.id_branch_ne;
    i.aluop = bus.id_aluop; i.memread = bus.id_memread; i.memwrite = bus.id_memwrite;
    i.memtoreg = bus.id_memtoreg; i.regdst = bus.id_regdst; i.regwrite = bus.id_regwrite;
    i.alusrc = bus.id_alusrc; i.jump = bus.id_jump; i.pc4 = bus.id_pc4;
    i.rs_data = bus.id_rs_data; i.rt_data = bus.id_rt_data; i.imm = bus.id_imm;
    i.rs = bus.id_rs; i.rt = bus.id_rt; i.rd = bus.id_rd;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i = '0;
    i.valid    = ($urandom_range(0, 9) != 0);
    i.memread  = ($urandom_range(0, 2) == 0);
    i.memwrite = !i.memread && ($urandom_range(0, 4) == 0);
    i.beq      = ($urandom_range(0, 7) == 0);
    i.bne      = !i.beq && ($urandom_range(0, 7) == 0);
    i.jump     = ($urandom_range(0, 9) == 0);
    i.alusrc   = i.memread | i.memwrite | ($urandom_range(0, 1) == 1);
    i.memtoreg = i.memread;
    i.regwrite = ($urandom_range(0, 1) == 1);
    i.regdst   = ($urandom_range(0, 1) == 1);
    i.aluop    = 6'($urandom_range(0, 63));
    i.pc4      = $urandom;  i.rs_data = $urandom;
    i.rt_data  = $urandom;  i.imm     = $urandom;
    i.rs = 5'($urandom_range(0, 3));
    i.rt = 5'($urandom_range(0, 3));
    i.rd = 5'($urandom_range(0, 31));
    return i;
  endfunction

  // Reference model: which instruction (if any) sits in EX.
  // m_full=0 means EX holds a dropped invalid slot, whose data fields are don't-care.
  instr_t m_ex;
  bit     m_full;
  int     m_bubbles;

  // ID must wait when the load in EX targets a nonzero register the ID instruction reads.
  function automatic bit hazard(input instr_t ex, input instr_t id);
    bit reads_rt;
    reads_rt = !id.alusrc || id.memwrite || id.beq || id.bne;
    return ex.valid && ex.memread && id.valid && (ex.rt != 5'd0) &&
           ((ex.rt == id.rs) || (reads_rt && (ex.rt == id.rt)));
  endfunction

  function automatic bit exp_stall();
    return (hazard(m_ex, cur_id()) && !bus.flush) || bus.ex_hold;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ex = '0; m_full = 1'b1; m_bubbles = 0;
    end else if (bus.flush) begin
      m_ex = '0; m_full = 1'b1; m_bubbles++;
    end else if (bus.ex_hold) begin
      m_ex = m_ex;
    end else if (hazard(m_ex, cur_id())) begin
      m_ex = '0; m_full = 1'b1; m_bubbles++;
    end else if (!bus.id_valid) begin
      m_ex = '0; m_full = 1'b0;
    end else begin
      m_ex = cur_id(); m_full = 1'b1;
    end
  end

  // scoreboard compare: every cycle out of reset
  always @(posedge clk) begin
    #2;
    if (rst) begin
      chk("ctrl", {bus.ex_valid, bus.ex_branch_eq, bus.ex_branch_ne, bus.ex_aluop,
                   bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg, bus.ex_regdst,
                   bus.ex_regwrite, bus.ex_alusrc, bus.ex_jump},
                  {m_ex.valid, m_ex.beq, m_ex.bne, m_ex.aluop, m_ex.memread, m_ex.memwrite,
                   m_ex.memtoreg, m_ex.regdst, m_ex.regwrite, m_ex.alusrc, m_ex.jump});
      if (m_full) begin
        chk("data", {bus.ex_pc4, bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm,
                     bus.ex_rs, bus.ex_rt, bus.ex_rd},
                    {m_ex.pc4, m_ex.rs_data, m_ex.rt_data, m_ex.imm, m_ex.rs, m_ex.rt, m_ex.rd});
        chk("wreg", bus.ex_wreg, m_ex.valid ? (m_ex.regdst ? m_ex.rd : m_ex.rt) : 5'd0);
      end
      chk("stall", bus.id_stall, exp_stall());
`ifdef ID_EX_STATS_EN
      chk("bubble_cnt", bubble_cnt, (m_bubbles > 65535) ? 16'hFFFF : 16'(m_bubbles));
`endif
    end
  end

  instr_t nop, addi, lw, add, x_i, y_i;

  initial begin
    nop = '0;
    set_id(nop);
    bus.flush = 1'b0;
    bus.ex_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", bus.ex_valid, 1'b0);
    chk("reset_wreg", bus.ex_wreg, 5'd0);
    chk("reset_stall", bus.id_stall, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // pass-through: addi rt=8 imm=5
    addi = '0; addi.valid = 1; addi.alusrc = 1; addi.regwrite = 1; addi.rs = 1;
    addi.rt = 8; addi.rd = 3; addi.imm = 5; addi.pc4 = 32'h104;
    cyc(addi, 0, 0); settle();
    chk("t2_wreg", bus.ex_wreg, 5'd8);
    chk("t2_alusrc", bus.ex_alusrc, 1'b1);
    chk("t2_valid", bus.ex_valid, 1'b1);
    chk("t2_regwrite", bus.ex_regwrite, 1'b1);
    chk("t2_model_wreg", m_ex.rt, 5'd8);

    // async reset mid-run
    cyc(nop, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("t1_regwrite", bus.ex_regwrite, 1'b0);
    chk("t1_valid", bus.ex_valid, 1'b0);
    chk("t1_imm", bus.ex_imm, 32'd0);
    chk("t1_stall", bus.id_stall, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // load-use: lw rt=9 then add rs=9
    lw = '0; lw.valid = 1; lw.memread = 1; lw.memtoreg = 1; lw.regwrite = 1;
    lw.alusrc = 1; lw.rs = 2; lw.rt = 9; lw.pc4 = 32'h200;
    add = '0; add.valid = 1; add.regdst = 1; add.regwrite = 1; add.aluop = 6'h20;
    add.rs = 9; add.rt = 4; add.rd = 10; add.pc4 = 32'h204;
    cyc(lw, 0, 0); settle();
    cyc(add, 0, 0); #1;
    chk("t3_stall", bus.id_stall, 1'b1);
    settle();
    chk("t3_bub_valid", bus.ex_valid, 1'b0);
    chk("t3_bub_regwrite", bus.ex_regwrite, 1'b0);
    chk("t3_stall_after", bus.id_stall, 1'b0);
    settle();
    chk("t3_add_valid", bus.ex_valid, 1'b1);
    chk("t3_add_wreg", bus.ex_wreg, 5'd10);

    // no false hazard: $0 target, and addi whose rt is only a destination
    lw.rt = 0;
    cyc(lw, 0, 0); settle();
    add.rs = 0;
    cyc(add, 0, 0); #1;
    chk("t4_zero_reg", bus.id_stall, 1'b0);
    lw.rt = 9;
    cyc(lw, 0, 0); settle();
    addi.rt = 9; addi.rs = 1;
    cyc(addi, 0, 0); #1;
    chk("t4_addi_rt", bus.id_stall, 1'b0);
    settle();

    // flush beats hold; hold alone freezes
    x_i = addi; x_i.pc4 = 32'h100; y_i = add; y_i.rs = 3; y_i.pc4 = 32'h200;
    cyc(x_i, 0, 0); settle();
    cyc(y_i, 1, 1); settle();
    chk("t5_flush_valid", bus.ex_valid, 1'b0);
    chk("t5_flush_pc4", bus.ex_pc4, 32'd0);
    cyc(x_i, 0, 0); settle();
    cyc(y_i, 0, 1);
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t5_hold_pc4", bus.ex_pc4, 32'h100);
      chk("t5_hold_valid", bus.ex_valid, 1'b1);
    end
    cyc(nop, 0, 0); settle();

    // randomized traffic; a stalled instruction is re-presented unchanged
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (!exp_stall() || bus.flush) set_id(rand_instr());
      bus.flush   = ($urandom_range(0, 9) == 0);
      bus.ex_hold = ($urandom_range(0, 6) == 0);
    end

`ifdef ID_EX_STATS_EN
    cyc(nop, 0, 0);
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    lw.rt = 9; add.rs = 9;
    for (int e = 0; e < 3; e++) begin
      cyc(lw, 0, 0); settle();
      cyc(add, 0, 0); settle(); settle();
    end
    cyc(nop, 1, 0); settle(); settle();
    chk("t6_cnt5", bubble_cnt, 16'd5);
    chk("t6_model5", m_bubbles, 5);
    repeat (65536) @(posedge clk);
    #3;
    chk("t6_sat", bubble_cnt, 16'hFFFF);
`endif

    cyc(nop, 0, 0); settle();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
